fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage that sits directly upstream of the control unit: it owns the program counter, requests 16-bit instructions from instruction memory over a req/ack handshake, and presents the fetched instruction in an IF/ID output register. The top nibble of that register drives the control unit's 4-bit `OpCode` input. The stage also accepts stall from downstream and branch/jump redirects (the control unit's `branch`/`bra` qualified by the execute stage), and buffers one instruction in a skid register so no fetched word is lost under stall.

## Interface
- `PC_W`, 8: program counter and instruction address width, in words.
- `INSTR_W`, 16: instruction width; `OpCode` is always `instr[INSTR_W-1:INSTR_W-4]`.
- `NOP_INSTR`, 16'h0000: value loaded into `instr` on reset and on flush.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `imemReq`  out  1  fetch request to instruction memory.
- `imemAddr`  out  PC_W  word address; stable while `imemReq` is high and not yet acked.
- `imemAck`  in  1  memory has `imemData` valid this cycle. May be high in the same cycle as the request it answers (zero-wait memory).
- `imemData`  in  INSTR_W  instruction word; sampled only when `imemAck`=1.
- `stall`  in  1  downstream cannot accept a new instruction; hold the output register.
- `redirect`  in  1  one-cycle pulse: taken branch or `bra` jump.
- `redirectPc`  in  PC_W  target address; sampled when `redirect`=1.
- `instr`  out  INSTR_W  IF/ID instruction register.
- `OpCode`  out  4  `instr[INSTR_W-1:INSTR_W-4]`, to the control unit.
- `instrPc`  out  PC_W  address of the instruction currently in `instr`.
- `instrValid`  out  1  `instr` holds a real fetched instruction, not a bubble.

## Operation
- The state machine has three states:
  - IDLE: entered on reset; `imemReq`=0. Always moves to FETCH on the next cycle.
  - FETCH: `imemReq`=1, `imemAddr`=`pc`.
  - HOLD: the skid register is full; `imemReq`=0.
- Ack in FETCH, no stall, no kill:
  - `instr`<=`imemData`, `instrPc`<=`pc`, `instrValid`<=1, `pc`<=`pc`+1.
  - Stay in FETCH, so back-to-back fetches give 1 instruction/cycle with zero-wait memory.
- Ack in FETCH while `stall`=1 and `instrValid`=1:
  - Capture the word into the skid register (data + pc), advance `pc`, go to HOLD.
  - The output register is unchanged.
- Ack while `stall`=1 and `instrValid`=0: the bubble is overwritten. It behaves as the no-stall case.
- HOLD exit: when `stall`=0, the skid contents move into `instr`/`instrPc`, `instrValid`=1, and the state returns to FETCH.
- Redirect has priority over stall and over ack. In the redirect cycle:
  - `pc`<=`redirectPc`.
  - Flush: `instr`<=`NOP_INSTR`, `instrValid`<=0, and the skid register is emptied.
  - State goes to FETCH.
- Redirect while a request is outstanding (FETCH, no ack this cycle):
  - Set `kill`. Keep `imemReq`/`imemAddr` at the old address until ack (the handshake is never abandoned).
  - The data returned with that ack is discarded and `kill` clears.
  - The request at `redirectPc` issues on the following cycle.
- Redirect coincident with ack: the data is discarded, `kill` is not set, and the next cycle requests `redirectPc`.
- Address wrap: `pc` wraps modulo 2^PC_W (all-ones + 1 = 0), with no flag.
- Stall with `instrValid`=0 and no ack: nothing changes.
- Reset mid-operation overrides everything:
  - Any outstanding request is dropped (`imemReq`=0 the next cycle).
  - `kill` is cleared and the skid register is emptied.

## Timing
- Reset values: `pc`=0, `imemReq`=0, `imemAddr`=0, `instr`=`NOP_INSTR`, `OpCode`=0, `instrPc`=0, `instrValid`=0, state=IDLE, skid empty, `kill`=0.
- First request: `imemReq` rises in the second cycle after `rst` deasserts (IDLE lasts one cycle).
- Latency: ack at edge n gives `instr`/`instrValid` updated at edge n+1.
- Redirect to first valid target instruction with zero-wait memory: 2 cycles.
- `OpCode` is combinational from `instr`; there is no extra register.
- All outputs except `OpCode` are registered.

## Test plan
- Reset then free run, zero-wait memory returning `16'h1000+addr`:
  - `imemReq` rises 2 cycles after reset.
  - `instr` shows 1000, 1001, 1002 on consecutive cycles with `instrPc` 0, 1, 2; `OpCode`=1.
- Stall for 3 cycles while `instr`=addr 2:
  - Addr 3 lands in the skid register, `imemReq` drops, `instr` holds addr 2.
  - After stall release, `instr`=addr 3 the next cycle, followed by addr 4; no word is lost or duplicated.
- Redirect to 8'h40 with `stall`=1 and skid full:
  - Next cycle: `instrValid`=0, `instr`=0000, skid empty.
  - The next request goes to address 0x40 and `instrPc`=0x40 once fetched.
- Memory with 2-cycle ack, redirect to 8'h20 one cycle after a request to 0x05:
  - `imemAddr` stays 0x05 until ack and that data is never output.
  - The following request is to 0x20.
- `pc` at 8'hFF: the fetch of FF is followed by a request to 00.
- Assert `rst` while a request is outstanding and a stall is active:
  - The next cycle shows all reset values and `imemReq`=0.
  - Fetching restarts at address 0.

Source files
------------

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage in front of the control unit. Owns the program
// counter, fetches instructions from instruction memory over a req/ack
// handshake and presents them in the IF/ID register. A one-entry skid register
// catches the word that arrives as downstream raises stall, so no fetched
// instruction is lost or duplicated. Branch/jump redirects flush the stage.
//
// Ports
//   clk, rst      clock; synchronous active-high reset
//   imemReq       fetch request to instruction memory (registered)
//   imemAddr      word address of the request (registered)
//   imemAck       memory returns imemData this cycle (may be same cycle as req)
//   imemData      instruction word, valid when imemAck=1
//   stall         downstream cannot take a new instruction
//   redirect      one-cycle pulse: taken branch / jump
//   redirectPc    target address, sampled with redirect
//   instr         IF/ID instruction register
//   OpCode        top nibble of instr (combinational) for the control unit
//   instrPc       address of the instruction in instr
//   instrValid    instr holds a real instruction rather than a bubble
// -----------------------------------------------------------------------------
module fetch_unit #(
   parameter int                  PC_W      = 8,
   parameter int                  INSTR_W   = 16,
   parameter logic [INSTR_W-1:0]  NOP_INSTR = 16'h0000
) (
   input  logic               clk,
   input  logic               rst,
   output logic               imemReq,
   output logic [PC_W-1:0]    imemAddr,
   input  logic               imemAck,
   input  logic [INSTR_W-1:0] imemData,
   input  logic               stall,
   input  logic               redirect,
   input  logic [PC_W-1:0]    redirectPc,
   output logic [INSTR_W-1:0] instr,
   output logic [3:0]         OpCode,
   output logic [PC_W-1:0]    instrPc,
   output logic               instrValid
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      HOLD  = 2'd2
   } stateT;

   stateT              stateReg,      stateNext;
   logic [PC_W-1:0]    pcReg,         pcNext;
   logic               imemReqReg,    imemReqNext;
   logic [PC_W-1:0]    imemAddrReg,   imemAddrNext;
   logic [INSTR_W-1:0] instrReg,      instrNext;
   logic [PC_W-1:0]    instrPcReg,    instrPcNext;
   logic               instrValidReg, instrValidNext;
   logic [INSTR_W-1:0] skidDataReg,   skidDataNext;
   logic [PC_W-1:0]    skidPcReg,     skidPcNext;
   // Set when a redirect lands on an unanswered request: the handshake must
   // still complete at the old address, but its data is thrown away.
   logic               killReg,       killNext;

   always_ff @(posedge clk) begin
      if (rst) begin
         stateReg      <= IDLE;
         pcReg         <= '0;
         imemReqReg    <= 1'b0;
         imemAddrReg   <= '0;
         instrReg      <= NOP_INSTR;
         instrPcReg    <= '0;
         instrValidReg <= 1'b0;
         skidDataReg   <= '0;
         skidPcReg     <= '0;
         killReg       <= 1'b0;
      end else begin
         stateReg      <= stateNext;
         pcReg         <= pcNext;
         imemReqReg    <= imemReqNext;
         imemAddrReg   <= imemAddrNext;
         instrReg      <= instrNext;
         instrPcReg    <= instrPcNext;
         instrValidReg <= instrValidNext;
         skidDataReg   <= skidDataNext;
         skidPcReg     <= skidPcNext;
         killReg       <= killNext;
      end
   end

   always_comb begin
      stateNext      = stateReg;
      pcNext         = pcReg;
      instrNext      = instrReg;
      instrPcNext    = instrPcReg;
      instrValidNext = instrValidReg;
      skidDataNext   = skidDataReg;
      skidPcNext     = skidPcReg;
      killNext       = killReg;

      if (redirect) begin
         // Flush wins over stall and ack. Leaving HOLD empties the skid.
         pcNext         = redirectPc;
         instrNext      = NOP_INSTR;
         instrValidNext = 1'b0;
         stateNext      = FETCH;
         // Only an unanswered request needs killing; an ack arriving now is
         // simply dropped.
         killNext       = (stateReg == FETCH) && !imemAck;
      end else begin
         case (stateReg)
            IDLE: begin
               stateNext = FETCH;
            end
            FETCH: begin
               if (imemAck) begin
                  if (killReg) begin
                     // Stale word from before the redirect; pc already holds
                     // the target.
                     killNext = 1'b0;
                  end else if (stall && instrValidReg) begin
                     skidDataNext = imemData;
                     skidPcNext   = pcReg;
                     pcNext       = pcReg + PC_W'(1);
                     stateNext    = HOLD;
                  end else begin
                     // A bubble under stall may be overwritten.
                     instrNext      = imemData;
                     instrPcNext    = pcReg;
                     instrValidNext = 1'b1;
                     pcNext         = pcReg + PC_W'(1);
                  end
               end
            end
            HOLD: begin
               if (!stall) begin
                  instrNext      = skidDataReg;
                  instrPcNext    = skidPcReg;
                  instrValidNext = 1'b1;
                  stateNext      = FETCH;
               end
            end
            default: begin
               stateNext = IDLE;
            end
         endcase
      end

      // The address stays on the outstanding request while it is being killed.
      imemAddrNext = killNext ? imemAddrReg : pcNext;
      imemReqNext  = (stateNext == FETCH);
   end

   assign imemReq    = imemReqReg;
   assign imemAddr   = imemAddrReg;
   assign instr      = instrReg;
   assign OpCode     = instrReg[INSTR_W-1 -: 4];
   assign instrPc    = instrPcReg;
   assign instrValid = instrValidReg;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        imemReq;
   logic [7:0]  imemAddr;
   logic        imemAck;
   logic [15:0] imemData;
   logic        stall;
   logic        redirect;
   logic [7:0]  redirectPc;
   logic [15:0] instr;
   logic [3:0]  OpCode;
   logic [7:0]  instrPc;
   logic        instrValid;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [15:0] data;
      logic [7:0]  addr;
   } expT;
   expT sb[$];

   // Memory model: word at addr is 16'h1000+addr; ack after ackDelay
   // unanswered cycles of a request (0 = zero-wait).
   logic [1:0] ackDelay = 2'd0;
   logic [3:0] waitCnt  = 4'd0;

   assign imemAck  = imemReq && (waitCnt >= {2'b00, ackDelay});
   assign imemData = 16'h1000 + {8'h00, imemAddr};

   always @(posedge clk) begin
      if (imemReq === 1'b1 && imemAck === 1'b0) waitCnt <= waitCnt + 4'd1;
      else                                       waitCnt <= 4'd0;
   end

   always #5 clk = ~clk;

   fetch_unit #(.PC_W(8), .INSTR_W(16), .NOP_INSTR(16'h0000)) dut (
      .clk        (clk),
      .rst        (rst),
      .imemReq    (imemReq),
      .imemAddr   (imemAddr),
      .imemAck    (imemAck),
      .imemData   (imemData),
      .stall      (stall),
      .redirect   (redirect),
      .redirectPc (redirectPc),
      .instr      (instr),
      .OpCode     (OpCode),
      .instrPc    (instrPc),
      .instrValid (instrValid)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic expectFetch(input logic [7:0] addr);
      expT e;
      e.addr = addr;
      e.data = 16'h1000 + {8'h00, addr};
      sb.push_back(e);
   endtask

   task automatic popCheck(input string tag);
      expT e;
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL %s observed=scoreboard-empty expected=entry", tag);
      end else begin
         e = sb.pop_front();
         $display("txn %s instr=%h instrPc=%h valid=%b (exp %h @ %h)",
                  tag, instr, instrPc, instrValid, e.data, e.addr);
         chk({tag, "_instr"}, 32'(instr), 32'(e.data));
         chk({tag, "_pc"},    32'(instrPc), 32'(e.addr));
         chk({tag, "_valid"}, 32'(instrValid), 32'd1);
      end
   endtask

   task automatic chkReset(input string tag);
      chk({tag, "_req"},    32'(imemReq),    32'd0);
      chk({tag, "_addr"},   32'(imemAddr),   32'd0);
      chk({tag, "_instr"},  32'(instr),      32'd0);
      chk({tag, "_opcode"}, 32'(OpCode),     32'd0);
      chk({tag, "_pc"},     32'(instrPc),    32'd0);
      chk({tag, "_valid"},  32'(instrValid), 32'd0);
   endtask

   initial begin
      rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirectPc = 8'h00;
      step();
      step();
      chkReset("reset");

      // Free run with zero-wait memory
      rst = 1'b0;
      chk("idle_req", 32'(imemReq), 32'd0);
      step();
      chk("first_req",  32'(imemReq),  32'd1);
      chk("first_addr", 32'(imemAddr), 32'd0);
      expectFetch(8'h00); expectFetch(8'h01); expectFetch(8'h02);
      step(); popCheck("run0");
      chk("run_opcode", 32'(OpCode), 32'd1);
      step(); popCheck("run1");
      step(); popCheck("run2");
      chk("run_addr3", 32'(imemAddr), 32'h03);

      // Stall for three cycles: addr 3 goes to the skid register
      stall = 1'b1;
      expectFetch(8'h03);
      step();
      chk("stall_req",   32'(imemReq), 32'd0);
      chk("stall_instr", 32'(instr),   32'h1002);
      chk("stall_pc",    32'(instrPc), 32'h02);
      step();
      chk("stall2_instr", 32'(instr), 32'h1002);
      step();
      chk("stall3_instr", 32'(instr),   32'h1002);
      chk("stall3_req",   32'(imemReq), 32'd0);
      stall = 1'b0;
      expectFetch(8'h04);
      step(); popCheck("skid3");
      chk("skid_req",  32'(imemReq),  32'd1);
      chk("skid_addr", 32'(imemAddr), 32'h04);
      step(); popCheck("after4");

      // Fill the skid with addr 5, then redirect to 0x40 under stall
      stall = 1'b1;
      step();
      chk("fill_req", 32'(imemReq), 32'd0);
      redirect = 1'b1; redirectPc = 8'h40;
      step();
      redirect = 1'b0;
      chk("flush_valid", 32'(instrValid), 32'd0);
      chk("flush_instr", 32'(instr),      32'h0000);
      chk("flush_req",   32'(imemReq),    32'd1);
      chk("flush_addr",  32'(imemAddr),   32'h40);
      expectFetch(8'h40);
      step(); popCheck("tgt40");
      stall = 1'b0;
      expectFetch(8'h41);
      step(); popCheck("tgt41");

      // Redirect coincident with a zero-wait ack at 0x42
      redirect = 1'b1; redirectPc = 8'h05;
      step();
      redirect = 1'b0;
      chk("coin_valid", 32'(instrValid), 32'd0);
      chk("coin_req",   32'(imemReq),    32'd1);
      chk("coin_addr",  32'(imemAddr),   32'h05);

      // Two-cycle memory: redirect to 0x20 while the request to 0x05 waits
      ackDelay = 2'd1;
      redirect = 1'b1; redirectPc = 8'h20;
      step();
      redirect = 1'b0;
      chk("kill_req",   32'(imemReq),    32'd1);
      chk("kill_addr",  32'(imemAddr),   32'h05);
      chk("kill_valid", 32'(instrValid), 32'd0);
      step();
      chk("killed_valid", 32'(instrValid), 32'd0);
      chk("killed_instr", 32'(instr),      32'h0000);
      chk("tgt20_addr",   32'(imemAddr),   32'h20);
      chk("tgt20_req",    32'(imemReq),    32'd1);
      step();
      chk("wait20_valid", 32'(instrValid), 32'd0);
      chk("wait20_addr",  32'(imemAddr),   32'h20);
      expectFetch(8'h20);
      step(); popCheck("tgt20");

      // Address wrap: fetch FE, FF, then 00
      ackDelay = 2'd0;
      redirect = 1'b1; redirectPc = 8'hFE;
      step();
      redirect = 1'b0;
      chk("wrap_flush_valid", 32'(instrValid), 32'd0);
      chk("wrap_addr_fe",     32'(imemAddr),   32'hFE);
      expectFetch(8'hFE); expectFetch(8'hFF);
      step(); popCheck("wrapFE");
      step(); popCheck("wrapFF");
      chk("wrap_addr_00", 32'(imemAddr), 32'h00);
      chk("wrap_req",     32'(imemReq),  32'd1);
      expectFetch(8'h00);
      step(); popCheck("wrap00");

      // Reset with a request outstanding and stall active
      ackDelay = 2'd1;
      chk("pre_rst_req",  32'(imemReq),  32'd1);
      chk("pre_rst_addr", 32'(imemAddr), 32'h01);
      stall = 1'b1; rst = 1'b1;
      step();
      chkReset("midrst");
      rst = 1'b0; stall = 1'b0; ackDelay = 2'd0;
      chk("restart_idle_req", 32'(imemReq), 32'd0);
      step();
      chk("restart_req",  32'(imemReq),  32'd1);
      chk("restart_addr", 32'(imemAddr), 32'h00);
      expectFetch(8'h00);
      step(); popCheck("restart0");

      chk("sb_empty", 32'(sb.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
